// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// per-register pending scoreboard and a held exception-capture pair.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned PC_W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  input  logic                     flush,
  input  logic                     xcpt_valid,
  input  logic [PC_W-1:0]          xcpt_pc,
  input  logic [AW-1:0]            xcpt_addr,
  input  logic                     rm_release,
  output logic [PC_W-1:0]          rm0,
  output logic [AW-1:0]            rm1,
  output logic                     rm_valid
);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] alloc_hit;
  logic [DATA_W-1:0]   wr_val [NUM_REGS];

  state_t state;
  state_t state_nxt;
  logic   capture;

  // Per-register write resolution; ascending scan lets the highest port win.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wr_hit[r]    = 1'b0;
      wr_val[r]    = '0;
      alloc_hit[r] = alloc_en && (alloc_addr == AW'(r));
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0) && (r == 0)) begin
        wr_hit[r]    = 1'b0;
        alloc_hit[r] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (flush) begin
        pending_nxt[r] = 1'b0;
      end else if (alloc_hit[r]) begin
        pending_nxt[r] = 1'b1;
      end else if (wr_hit[r]) begin
        pending_nxt[r] = 1'b0;
      end else begin
        pending_nxt[r] = pending[r];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_val;
    logic              zero_sel;
    logic              alloc_same;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      byp_hit    = 1'b0;
      byp_val    = '0;
      zero_sel   = (ZERO_REG != 0) && (addr == '0);
      alloc_same = alloc_en && (alloc_addr == addr);
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
          byp_hit = 1'b1;
          byp_val = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if ((BYPASS == 0) || zero_sel) begin
        byp_hit = 1'b0;
      end
    end

    // A same-cycle alloc keeps the bit visible even though a write lands too.
    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = regs[addr];
      rd_pending[k]               = pending[addr];
      if (byp_hit) begin
        rd_data[k*DATA_W +: DATA_W] = byp_val;
        if (!alloc_same) begin
          rd_pending[k] = 1'b0;
        end
      end
      if (zero_sel || reset) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_pending[k]               = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (xcpt_valid) begin
          capture   = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (rm_release) begin
          if (xcpt_valid) begin
            capture = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rm0   <= '0;
      rm1   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rm0 <= xcpt_pc;
        rm1 <= xcpt_addr;
      end
    end
  end

  assign rm_valid = (state == HELD);

endmodule
